ram_responder: RTL and testbench
================================

Name: ram_responder

Overview:
- Simulation and FPGA RAM model on the RAM side of the arbitration interface.
- Sits below the memory controller and answers its ramREN/ramWEN/ramaddr/ramstore requests.
- Reports progress on ramstate (FREE/BUSY/ACCESS/ERROR, ramstate_t from cpu_types_pkg) and returns read data on ramload.
- Access latency is configurable so the controller's wait/arbitration logic can be exercised under stall.

Parameters:
LAT, 2, number of BUSY cycles before ACCESS (0..15; 0 = ACCESS on the cycle after capture)
DEPTH_LOG2, 14, log2 of the number of 32-bit words stored

Ports:
CLK  in  1  clock, all state on rising edge
RST  in  1  reset, synchronous, active-high
ramREN  in  1  read request, held until ACCESS seen
ramWEN  in  1  write request, held until ACCESS seen
ramaddr  in  32  byte address, word aligned
ramstore  in  32  write data
ramload  out  32  read data, valid during ACCESS of a read
ramstate  out  ramstate_t (2)  FREE, BUSY, ACCESS, ERROR

Behaviour:
- Reset (RST high at a CLK edge): ramstate=FREE, ramload=0, latency counter=0, captured request cleared. Memory array is not cleared.
- Valid request: exactly one of ramREN/ramWEN high, ramaddr[1:0]==0, and ramaddr[31:DEPTH_LOG2+2]==0. Word index = ramaddr[DEPTH_LOG2+1:2].
- State FREE:
  - Valid request at edge: capture {op, addr}, load counter with LAT. Next state is BUSY if LAT>0, else ACCESS.
  - Invalid request (both enables, misaligned, or out of range): next state ERROR.
  - No request: stay FREE.
- State BUSY:
  - Each edge decrements the counter. Leave for ACCESS on the edge where the counter reaches 0 (LAT BUSY cycles total).
  - If ramREN, ramWEN or ramaddr differs from the captured value: abort. A new valid request recaptures and restarts the full LAT count. A dropped request goes to FREE. An invalid request goes to ERROR.
- Read ramload: registered, loaded with mem[captured word] on the edge entering ACCESS for a read. Holds its value otherwise (including during ACCESS of a write).
- State ACCESS: exactly one cycle, then FREE unconditionally.
  - For a write, mem[captured word] <= ramstore on the edge leaving ACCESS, using ramstore sampled that cycle.
  - A request still asserted in the cycle after ACCESS is treated as a new request from FREE. Back-to-back throughput is one access per LAT+2 cycles.
- State ERROR: no memory update. Stays ERROR while the request is invalid, goes to FREE when both enables are low. A valid request in ERROR goes to FREE first (no direct capture).
- Read-after-write to the same word returns the new data. The write commits before any later ACCESS can load.
- RST mid-access: request discarded, no write performed, state FREE next cycle.
- ramstate is a registered output with no combinational path from the inputs.

Test Plan:
- LAT=2: write 0xDEADBEEF to 0x00000100 (ramWEN=1 held) -> ramstate FREE, BUSY, BUSY, ACCESS, FREE on successive cycles. Then read 0x100 -> ramload=0xDEADBEEF during its ACCESS cycle.
- LAT=0: read 0x0 immediately after reset -> ACCESS on the cycle after ramREN rises, ramload=mem[0]. Hold ramREN continuously -> ACCESS every 2nd cycle.
- Address change mid-BUSY: LAT=3 read 0x10, change ramaddr to 0x20 after 1 BUSY cycle -> 3 more BUSY cycles, then ACCESS with ramload=mem[0x20/4].
- ramREN=ramWEN=1 -> ERROR next cycle and held while both high. Both low -> FREE. Memory unchanged. ramaddr=0x3 with ramREN -> ERROR.
- RST asserted during BUSY of a write of 0x12345678 to 0x40 -> FREE, ramload=0, mem[0x10] keeps its old value.
- Write 0xA5A5A5A5 to 0x8, then immediately read 0x8 with no idle cycle besides the mandatory FREE -> ramload=0xA5A5A5A5.

Source files
------------

// File: rtl/ram_responder.sv
// Word-addressed RAM model answering memory-controller requests with a
// configurable number of BUSY cycles before the single ACCESS cycle.
package cpu_types_pkg;
  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;
endpackage

module ram_responder
  import cpu_types_pkg::*;
#(
  parameter int LAT        = 2,
  parameter int DEPTH_LOG2 = 14
) (
  input  logic      CLK,
  input  logic      RST,
  input  logic      ramREN,
  input  logic      ramWEN,
  input  logic [31:0] ramaddr,
  input  logic [31:0] ramstore,
  output logic [31:0] ramload,
  output ramstate_t ramstate
);

  localparam logic [3:0] LAT_CNT = 4'(LAT);

  logic [31:0] mem [0:(1<<DEPTH_LOG2)-1];

  ramstate_t   state_reg;
  logic [3:0]  cnt_reg;
  logic        cap_ren_reg;
  logic        cap_wen_reg;
  logic [31:0] cap_addr_reg;

  logic                  req_any;
  logic                  req_valid;
  logic                  changed;
  logic [DEPTH_LOG2-1:0] rd_idx;
  logic [DEPTH_LOG2-1:0] cap_idx;

  assign req_any   = ramREN | ramWEN;
  assign req_valid = (ramREN ^ ramWEN) && (ramaddr[1:0] == 2'b00) &&
                     (ramaddr[31:DEPTH_LOG2+2] == '0);
  assign changed   = (ramREN != cap_ren_reg) || (ramWEN != cap_wen_reg) ||
                     (ramaddr != cap_addr_reg);
  assign cap_idx   = cap_addr_reg[DEPTH_LOG2+1:2];
  // Only a zero-latency capture reads straight from the bus; otherwise the
  // captured address is used, so the array keeps a single read port.
  assign rd_idx    = (state_reg == FREE) ? ramaddr[DEPTH_LOG2+1:2] : cap_idx;

  assign ramstate  = state_reg;

  always_ff @(posedge CLK) begin
    if (!RST && state_reg == ACCESS && cap_wen_reg) begin
      mem[cap_idx] <= ramstore;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg    <= FREE;
      ramload      <= '0;
      cnt_reg      <= '0;
      cap_ren_reg  <= 1'b0;
      cap_wen_reg  <= 1'b0;
      cap_addr_reg <= '0;
    end else begin
      case (state_reg)
        FREE: begin
          if (req_any) begin
            if (req_valid) begin
              cap_ren_reg  <= ramREN;
              cap_wen_reg  <= ramWEN;
              cap_addr_reg <= ramaddr;
              cnt_reg      <= LAT_CNT;
              if (LAT == 0) begin
                state_reg <= ACCESS;
                if (ramREN) ramload <= mem[rd_idx];
              end else begin
                state_reg <= BUSY;
              end
            end else begin
              state_reg <= ERROR;
            end
          end
        end
        BUSY: begin
          if (changed) begin
            // Any change of the request aborts the pending access.
            if (!req_any) begin
              state_reg <= FREE;
            end else if (req_valid) begin
              cap_ren_reg  <= ramREN;
              cap_wen_reg  <= ramWEN;
              cap_addr_reg <= ramaddr;
              cnt_reg      <= LAT_CNT;
            end else begin
              state_reg <= ERROR;
            end
          end else if (cnt_reg <= 4'd1) begin
            cnt_reg   <= '0;
            state_reg <= ACCESS;
            if (cap_ren_reg) ramload <= mem[rd_idx];
          end else begin
            cnt_reg <= cnt_reg - 4'd1;
          end
        end
        ACCESS: begin
          state_reg <= FREE;
        end
        default: begin
          // A valid request only clears the error; it is captured from FREE.
          if (req_any && !req_valid) state_reg <= ERROR;
          else                       state_reg <= FREE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_responder.sv
// Directed bench for ram_responder: three instances with LAT 0, 2 and 3,
// each driven by its own request signals.
module tb_ram_responder;
  import cpu_types_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        ren   [3];
  logic        wen   [3];
  logic [31:0] addr  [3];
  logic [31:0] store [3];
  logic [31:0] load  [3];
  ramstate_t   state [3];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ram_responder #(.LAT(0), .DEPTH_LOG2(8)) u_lat0 (
    .CLK(clk), .RST(rst), .ramREN(ren[0]), .ramWEN(wen[0]), .ramaddr(addr[0]),
    .ramstore(store[0]), .ramload(load[0]), .ramstate(state[0]));
  ram_responder #(.LAT(2), .DEPTH_LOG2(8)) u_lat2 (
    .CLK(clk), .RST(rst), .ramREN(ren[1]), .ramWEN(wen[1]), .ramaddr(addr[1]),
    .ramstore(store[1]), .ramload(load[1]), .ramstate(state[1]));
  ram_responder #(.LAT(3), .DEPTH_LOG2(8)) u_lat3 (
    .CLK(clk), .RST(rst), .ramREN(ren[2]), .ramWEN(wen[2]), .ramaddr(addr[2]),
    .ramstore(store[2]), .ramload(load[2]), .ramstate(state[2]));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic r, input logic w,
                         input logic [31:0] a, input logic [31:0] d);
    ren[i]   = r;
    wen[i]   = w;
    addr[i]  = a;
    store[i] = d;
  endtask

  // Issue one request, hold it until ACCESS, then release and step once.
  task automatic access(input int i, input logic w, input logic [31:0] a,
                        input logic [31:0] d, output logic [31:0] ld);
    int n;
    set_req(i, !w, w, a, d);
    n = 0;
    do begin
      tick();
      n++;
    end while (state[i] !== ACCESS && n < 40);
    if (state[i] !== ACCESS) begin
      total++; bad++;
      $display("FAIL access_timeout inst=%0d state=%0d required=%0d", i, state[i], ACCESS);
    end
    ld = load[i];
    $display("txn inst=%0d op=%s addr=%h data=%h load=%h cycles=%0d",
             i, w ? "WR" : "RD", a, d, ld, n);
    set_req(i, 1'b0, 1'b0, a, d);
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) set_req(i, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      total++;
      if (state[i] !== FREE) begin
        bad++; $display("FAIL reset_state inst=%0d got=%0d want=%0d", i, state[i], FREE);
      end
      total++;
      if (load[i] !== 32'h0) begin
        bad++; $display("FAIL reset_load inst=%0d got=%h want=0", i, load[i]);
      end
    end
  endtask

  task automatic test_write_read_lat2();
    ramstate_t   exp_seq [4];
    logic [31:0] ld;
    exp_seq = '{BUSY, BUSY, ACCESS, FREE};
    set_req(1, 1'b0, 1'b1, 32'h100, 32'hDEADBEEF);
    total++;
    if (state[1] !== FREE) begin
      bad++; $display("FAIL wr_start got=%0d want=%0d", state[1], FREE);
    end
    for (int k = 0; k < 4; k++) begin
      tick();
      total++;
      if (state[1] !== exp_seq[k]) begin
        bad++; $display("FAIL wr_seq step=%0d got=%0d want=%0d", k, state[1], exp_seq[k]);
      end
      if (k == 2) set_req(1, 1'b0, 1'b0, 32'h100, 32'hDEADBEEF);
    end
    $display("txn inst=1 op=WR addr=00000100 data=deadbeef");
    access(1, 1'b0, 32'h100, 32'h0, ld);
    total++;
    if (ld !== 32'hDEADBEEF) begin
      bad++; $display("FAIL rd_after_wr got=%h want=deadbeef", ld);
    end
  endtask

  task automatic test_lat0();
    logic [31:0] ld;
    access(0, 1'b1, 32'h0, 32'h11112222, ld);
    rst = 1'b1;
    tick();
    total++;
    if (load[0] !== 32'h0) begin
      bad++; $display("FAIL lat0_reset_load got=%h want=0", load[0]);
    end
    rst = 1'b0;
    set_req(0, 1'b1, 1'b0, 32'h0, 32'h0);
    tick();
    total++;
    if (state[0] !== ACCESS) begin
      bad++; $display("FAIL lat0_first got=%0d want=%0d", state[0], ACCESS);
    end
    total++;
    if (load[0] !== 32'h11112222) begin
      bad++; $display("FAIL lat0_load got=%h want=11112222", load[0]);
    end
    for (int k = 0; k < 4; k++) begin
      tick();
      total++;
      if (state[0] !== ((k % 2 == 0) ? FREE : ACCESS)) begin
        bad++; $display("FAIL lat0_held step=%0d got=%0d", k, state[0]);
      end
    end
    $display("txn inst=0 op=RD addr=00000000 held load=%h", load[0]);
    set_req(0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
  endtask

  task automatic test_abort();
    logic [31:0] ld;
    access(2, 1'b1, 32'h10, 32'h0000AAAA, ld);
    access(2, 1'b1, 32'h20, 32'h0000BBBB, ld);
    set_req(2, 1'b1, 1'b0, 32'h10, 32'h0);
    tick();
    total++;
    if (state[2] !== BUSY) begin
      bad++; $display("FAIL abort_busy0 got=%0d want=%0d", state[2], BUSY);
    end
    set_req(2, 1'b1, 1'b0, 32'h20, 32'h0);
    for (int k = 0; k < 3; k++) begin
      tick();
      total++;
      if (state[2] !== BUSY) begin
        bad++; $display("FAIL abort_busy step=%0d got=%0d want=%0d", k, state[2], BUSY);
      end
    end
    tick();
    total++;
    if (state[2] !== ACCESS) begin
      bad++; $display("FAIL abort_access got=%0d want=%0d", state[2], ACCESS);
    end
    total++;
    if (load[2] !== 32'h0000BBBB) begin
      bad++; $display("FAIL abort_load got=%h want=0000bbbb", load[2]);
    end
    $display("txn inst=2 op=RD addr=00000010->00000020 load=%h", load[2]);
    set_req(2, 1'b0, 1'b0, 32'h20, 32'h0);
    tick();
    total++;
    if (state[2] !== FREE) begin
      bad++; $display("FAIL abort_free got=%0d want=%0d", state[2], FREE);
    end
  endtask

  task automatic test_error();
    logic [31:0] ld;
    set_req(1, 1'b1, 1'b1, 32'h100, 32'h0);
    for (int k = 0; k < 3; k++) begin
      tick();
      total++;
      if (state[1] !== ERROR) begin
        bad++; $display("FAIL err_both step=%0d got=%0d want=%0d", k, state[1], ERROR);
      end
    end
    set_req(1, 1'b0, 1'b0, 32'h100, 32'h0);
    tick();
    total++;
    if (state[1] !== FREE) begin
      bad++; $display("FAIL err_clear got=%0d want=%0d", state[1], FREE);
    end
    access(1, 1'b0, 32'h100, 32'h0, ld);
    total++;
    if (ld !== 32'hDEADBEEF) begin
      bad++; $display("FAIL err_mem_kept got=%h want=deadbeef", ld);
    end
    set_req(1, 1'b1, 1'b0, 32'h3, 32'h0);
    tick();
    total++;
    if (state[1] !== ERROR) begin
      bad++; $display("FAIL err_misaligned got=%0d want=%0d", state[1], ERROR);
    end
    set_req(1, 1'b1, 1'b0, 32'h400, 32'h0);
    tick();
    total++;
    if (state[1] !== ERROR) begin
      bad++; $display("FAIL err_range got=%0d want=%0d", state[1], ERROR);
    end
    set_req(1, 1'b1, 1'b0, 32'h100, 32'h0);
    tick();
    total++;
    if (state[1] !== FREE) begin
      bad++; $display("FAIL err_valid_free got=%0d want=%0d", state[1], FREE);
    end
    tick();
    total++;
    if (state[1] !== BUSY) begin
      bad++; $display("FAIL err_then_busy got=%0d want=%0d", state[1], BUSY);
    end
    set_req(1, 1'b0, 1'b0, 32'h100, 32'h0);
    tick();
    tick();
  endtask

  task automatic test_reset_mid();
    logic [31:0] ld;
    access(1, 1'b1, 32'h40, 32'h0BADF00D, ld);
    set_req(1, 1'b0, 1'b1, 32'h40, 32'h12345678);
    tick();
    total++;
    if (state[1] !== BUSY) begin
      bad++; $display("FAIL rstmid_busy got=%0d want=%0d", state[1], BUSY);
    end
    rst = 1'b1;
    tick();
    total++;
    if (state[1] !== FREE) begin
      bad++; $display("FAIL rstmid_state got=%0d want=%0d", state[1], FREE);
    end
    total++;
    if (load[1] !== 32'h0) begin
      bad++; $display("FAIL rstmid_load got=%h want=0", load[1]);
    end
    rst = 1'b0;
    set_req(1, 1'b0, 1'b0, 32'h40, 32'h0);
    tick();
    access(1, 1'b0, 32'h40, 32'h0, ld);
    total++;
    if (ld !== 32'h0BADF00D) begin
      bad++; $display("FAIL rstmid_mem got=%h want=0badf00d", ld);
    end
  endtask

  task automatic test_back_to_back();
    set_req(1, 1'b0, 1'b1, 32'h8, 32'hA5A5A5A5);
    for (int n = 0; n < 10; n++) begin
      tick();
      if (state[1] === ACCESS) break;
    end
    total++;
    if (state[1] !== ACCESS) begin
      bad++; $display("FAIL b2b_wr_access got=%0d want=%0d", state[1], ACCESS);
    end
    $display("txn inst=1 op=WR addr=00000008 data=a5a5a5a5");
    // Switch to the read in the write's ACCESS cycle; write data stays valid.
    set_req(1, 1'b1, 1'b0, 32'h8, 32'hA5A5A5A5);
    tick();
    total++;
    if (state[1] !== FREE) begin
      bad++; $display("FAIL b2b_free got=%0d want=%0d", state[1], FREE);
    end
    tick();
    tick();
    tick();
    total++;
    if (state[1] !== ACCESS) begin
      bad++; $display("FAIL b2b_rd_access got=%0d want=%0d", state[1], ACCESS);
    end
    total++;
    if (load[1] !== 32'hA5A5A5A5) begin
      bad++; $display("FAIL b2b_load got=%h want=a5a5a5a5", load[1]);
    end
    $display("txn inst=1 op=RD addr=00000008 load=%h", load[1]);
    for (int k = 0; k < 4; k++) tick();
    total++;
    if (state[1] !== ACCESS) begin
      bad++; $display("FAIL b2b_rate got=%0d want=%0d", state[1], ACCESS);
    end
    set_req(1, 1'b0, 1'b0, 32'h8, 32'h0);
    tick();
  endtask

  initial begin
    test_reset();
    test_write_read_lat2();
    test_lat0();
    test_abort();
    test_error();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
